// File: rtl/mac_pkg.sv
// Shared types for the MAC tx bus: receiver FSM states, FIFO entry layout and byte-lane legality.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        eop;
  } rx_entry_t;

  localparam logic [3:0] KEEP_1B = 4'b0001;
  localparam logic [3:0] KEEP_2B = 4'b0011;
  localparam logic [3:0] KEEP_3B = 4'b0111;
  localparam logic [3:0] KEEP_4B = 4'b1111;

  // Partial patterns are only legal on the last beat; that ordering rule is enforced by the caller.
  function automatic logic keep_legal(input logic [3:0] keep);
    return keep inside {KEEP_1B, KEEP_2B, KEEP_3B, KEEP_4B};
  endfunction

endpackage

// File: rtl/mac_rx_fifo_ram.sv
// Frame buffer storage: DEPTH entries of rx_entry_t, one synchronous write port, one async read port.
module mac_rx_fifo_ram
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rx_entry_t     wr_entry,
  input  logic [AW-1:0] rd_addr,
  output rx_entry_t     rd_entry
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_entry;
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/mac_frame_receiver.sv
// Store-and-forward MAC tx-bus receiver: only complete, well-formed frames reach the output stream.
// Optional statistics counters (frame_cnt/drop_cnt) are enabled by defining MAC_RX_STATS_EN.
module mac_frame_receiver
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_frame,
  input  logic [3:0]       tx_valid,
  input  logic [31:0]      tx_data,
`ifdef MAC_RX_STATS_EN
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_keep,
  output logic             out_sop,
  output logic             out_eop
);

  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam int unsigned     PW      = AW + 1;
  localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);

  rx_state_e     state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, commit_ptr;
  logic          hold_valid;
  logic [31:0]   hold_data;
  logic [3:0]    hold_keep;

  logic          data_beat, beat_bad, full, pop;
  logic          wr_en, wr_eop, hold_load, do_commit, do_rewind;
  rx_entry_t     wr_entry, rd_entry;

  assign data_beat = tx_frame && (tx_valid != '0);
  assign beat_bad  = !keep_legal(tx_valid) || (hold_valid && (hold_keep != KEEP_4B));
  assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
  assign out_valid = rd_ptr != commit_ptr;
  assign pop       = out_valid && out_ready;

  // The held beat is only written once its successor (or frame end) decides its eop flag.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_eop    = 1'b0;
    hold_load = 1'b0;
    do_commit = 1'b0;
    do_rewind = 1'b0;
    case (state)
      IDLE, RECV: begin
        if (tx_frame) begin
          state_nxt = RECV;
          if (data_beat) begin
            if (beat_bad || (hold_valid && full)) begin
              state_nxt = DROP;
            end else begin
              wr_en     = hold_valid;
              hold_load = 1'b1;
            end
          end
        end else if (state == RECV) begin
          state_nxt = IDLE;
          if (hold_valid) begin
            if (full) begin
              do_rewind = 1'b1;
            end else begin
              wr_en     = 1'b1;
              wr_eop    = 1'b1;
              do_commit = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!tx_frame) begin
          state_nxt = IDLE;
          do_rewind = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_keep  <= '0;
      out_sop    <= 1'b1;
    end else begin
      state <= state_nxt;
      if (do_rewind) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_commit) commit_ptr <= wr_ptr + PW'(1);
      if (hold_load) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_data;
        hold_keep  <= tx_valid;
      end else if (do_commit || do_rewind) begin
        hold_valid <= 1'b0;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        out_sop <= rd_entry.eop;
      end
    end
  end

  assign wr_entry = '{data: hold_data, keep: hold_keep, eop: wr_eop};

  mac_rx_fifo_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_entry(wr_entry),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_entry(rd_entry)
  );

  assign out_data = rd_entry.data;
  assign out_keep = rd_entry.keep;
  assign out_eop  = rd_entry.eop;

`ifdef MAC_RX_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (do_commit && (frame_cnt != '1)) frame_cnt <= frame_cnt + CNT_W'(1);
      if (do_rewind && (drop_cnt != '1))  drop_cnt  <= drop_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mac_frame_receiver.sv
// Bench for mac_frame_receiver: frame-level reference model feeding an expected-word queue,
// a lane-legality vector table, directed corner sequences and a randomized stall run.
module tb_mac_frame_receiver;
  import mac_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_frame = 1'b0;
  logic [3:0]  tx_valid = '0;
  logic [31:0] tx_data = '0;
  logic        out_valid, out_sop, out_eop;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
`ifdef MAC_RX_STATS_EN
  logic [CNT_W-1:0] frame_cnt, drop_cnt;
`endif

  mac_frame_receiver #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_frame (tx_frame),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
`ifdef MAC_RX_STATS_EN
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_sop  (out_sop),
    .out_eop  (out_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        sop;
    logic        eop;
  } word_t;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    bit          exp_out;
    bit          exp_drop;
  } vec_t;

  word_t       exp_q[$];
  logic [3:0]  cur_v[$];
  logic [31:0] cur_d[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_popped = 0;
  int          m_frames = 0;
  int          m_drops  = 0;
  bit          rand_ready  = 1'b0;
  logic        ready_force = 1'b0;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  always @(negedge clk) begin
    word_t e;
    if (rst && out_valid && out_ready) begin
      n_popped++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got data=%h keep=%b sop=%b eop=%b, required no word",
                 out_data, out_keep, out_sop, out_eop);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_keep, out_sop, out_eop} !== {e.data, e.keep, e.sop, e.eop}) begin
          n_fail++;
          $display("FAIL out_word: got data=%h keep=%b sop=%b eop=%b, required data=%h keep=%b sop=%b eop=%b",
                   out_data, out_keep, out_sop, out_eop, e.data, e.keep, e.sop, e.eop);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic check_cnts(input string name);
`ifdef MAC_RX_STATS_EN
    check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frames));
    check({name, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drops));
`else
    check({name, "_no_stray_output"}, 64'(out_valid), 64'd0);
`endif
  endtask

  // Frame rule: every data beat is full, except the final data beat which may be 1..3 low lanes.
  task automatic model_frame();
    int    last;
    bit    good;
    bit    first;
    word_t w;
    last  = -1;
    good  = 1'b1;
    first = 1'b1;
    for (int i = 0; i < cur_v.size(); i++) if (cur_v[i] != 4'h0) last = i;
    if (last < 0) return;
    for (int i = 0; i < cur_v.size(); i++) begin
      if (cur_v[i] != 4'h0 && !(cur_v[i] == 4'hF ||
          (i == last && (cur_v[i] == 4'h1 || cur_v[i] == 4'h3 || cur_v[i] == 4'h7))))
        good = 1'b0;
    end
    if (!good) begin
      m_drops++;
      return;
    end
    for (int i = 0; i < cur_v.size(); i++) begin
      if (cur_v[i] != 4'h0) begin
        w.data = cur_d[i];
        w.keep = cur_v[i];
        w.sop  = first;
        w.eop  = (i == last);
        first  = 1'b0;
        exp_q.push_back(w);
      end
    end
    m_frames++;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < cur_v.size(); i++) begin
      tx_frame = 1'b1;
      tx_valid = cur_v[i];
      tx_data  = cur_d[i];
      @(posedge clk); #1;
    end
    tx_frame = 1'b0;
    tx_valid = 4'($urandom);
    tx_data  = $urandom;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  task automatic set_frame1(input logic [3:0] v, input logic [31:0] d);
    cur_v.delete(); cur_d.delete();
    cur_v.push_back(v); cur_d.push_back(d);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   p0;
    tbl[0] = '{4'hF, 32'hA1B2C3D4, 1'b1, 1'b0};
    tbl[1] = '{4'h1, 32'h000000E1, 1'b1, 1'b0};
    tbl[2] = '{4'h3, 32'h0000E2E3, 1'b1, 1'b0};
    tbl[3] = '{4'h7, 32'h00E4E5E6, 1'b1, 1'b0};
    tbl[4] = '{4'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[5] = '{4'h5, 32'h55555555, 1'b0, 1'b1};
    tbl[6] = '{4'h8, 32'h88888888, 1'b0, 1'b1};
    tbl[7] = '{4'hE, 32'hEEEEEEEE, 1'b0, 1'b1};
    tbl[8] = '{4'h2, 32'h22222222, 1'b0, 1'b1};
    tbl[9] = '{4'hB, 32'hBBBBBBBB, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_sop", 64'(out_sop), 64'd1);
    check_cnts("reset");
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end

    // 3-word frame with output held off, checking commit latency
    cur_v = '{4'hF, 4'hF, 4'h3};
    cur_d = '{32'h03020100, 32'h07060504, 32'h00000908};
    model_frame();
    send_frame(0);
    check("latency_before_commit", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_after_commit", 64'(out_valid), 64'd1);
    check("first_word_sop", 64'(out_sop), 64'd1);
    ready_force = 1'b1;
    wait_drain("three_word");
    check_cnts("three_word");

    // malformed lane pattern mid-frame, then a good frame
    p0 = n_popped;
    cur_v = '{4'hF, 4'h5, 4'hF};
    cur_d = '{32'h11110000, 32'h11110001, 32'h11110002};
    model_frame();
    send_frame(1);
    cur_v = '{4'hF, 4'hF, 4'h1};
    cur_d = '{32'h22220000, 32'h22220001, 32'h000000AA};
    model_frame();
    send_frame(1);
    wait_drain("malformed");
    check("malformed_words", 64'(n_popped - p0), 64'd3);
    check_cnts("malformed");

    // overflow: DEPTH+1 words with output stalled
    ready_force = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    cur_v.delete(); cur_d.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      cur_v.push_back(4'hF);
      cur_d.push_back(32'h33330000 + 32'(i));
    end
    m_drops++;
    send_frame(1);
    check("overflow_no_output", 64'(out_valid), 64'd0);
    cur_v = '{4'hF, 4'h7};
    cur_d = '{32'h44440000, 32'h00444401};
    model_frame();
    send_frame(1);
    check("after_overflow_valid", 64'(out_valid), 64'd1);
    check("after_overflow_sop", 64'(out_sop), 64'd1);
    ready_force = 1'b1;
    wait_drain("overflow");
    check_cnts("overflow");

    // back-to-back single-word frames with one idle cycle between
    p0 = n_popped;
    set_frame1(4'hF, 32'h55550000);
    model_frame();
    send_frame(1);
    set_frame1(4'hF, 32'h55550001);
    model_frame();
    send_frame(1);
    wait_drain("back_to_back");
    check("back_to_back_words", 64'(n_popped - p0), 64'd2);
    check_cnts("back_to_back");

    // reset in the middle of a frame
    tx_frame = 1'b1;
    tx_valid = 4'hF;
    tx_data  = 32'h66660000;
    @(posedge clk); #1;
    tx_data  = 32'h66660001;
    @(posedge clk); #1;
    rst      = 1'b0;
    tx_frame = 1'b0;
    @(posedge clk); #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_sop", 64'(out_sop), 64'd1);
    rst = 1'b1;
    m_frames = 0;
    m_drops  = 0;
    exp_q.delete();
    @(posedge clk); #1;
    p0 = n_popped;
    set_frame1(4'hF, 32'h77770000);
    model_frame();
    send_frame(1);
    wait_drain("midreset");
    check("midreset_words", 64'(n_popped - p0), 64'd1);
    check_cnts("midreset");

    // single-beat lane-legality table
    for (int i = 0; i < 10; i++) begin
      word_t w;
      p0 = n_popped;
      if (tbl[i].exp_out) begin
        w.data = tbl[i].d;
        w.keep = tbl[i].v;
        w.sop  = 1'b1;
        w.eop  = 1'b1;
        exp_q.push_back(w);
        m_frames++;
      end
      if (tbl[i].exp_drop) m_drops++;
      set_frame1(tbl[i].v, tbl[i].d);
      send_frame(1);
      wait_drain($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_words", i), 64'(n_popped - p0), 64'(tbl[i].exp_out));
      check_cnts($sformatf("tbl%0d", i));
    end

    // randomized frames with output stalls and pointer wrap
    rand_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int nw;
      int nb;
      int t;
      logic [3:0] bad_list[11];
      bad_list = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
      nw = $urandom_range(1, DEPTH);
      cur_v.delete(); cur_d.delete();
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          cur_v.push_back(4'h0);
          cur_d.push_back($urandom);
        end
        if (k == nw - 1) begin
          case ($urandom_range(0, 3))
            0: cur_v.push_back(4'h1);
            1: cur_v.push_back(4'h3);
            2: cur_v.push_back(4'h7);
            default: cur_v.push_back(4'hF);
          endcase
        end else begin
          cur_v.push_back(4'hF);
        end
        cur_d.push_back($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        int idx;
        idx = $urandom_range(0, cur_v.size() - 1);
        if ($urandom_range(0, 1) == 0) cur_v[idx] = bad_list[$urandom_range(0, 10)];
        else cur_v[idx] = 4'h3;
      end
      nb = 0;
      for (int k = 0; k < cur_v.size(); k++) if (cur_v[k] != 4'h0) nb++;
      t = 0;
      while (exp_q.size() + nb > DEPTH && t < 2000) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 2000) check("room_timeout", 64'd1, 64'd0);
      model_frame();
      send_frame($urandom_range(1, 3));
    end
    wait_drain("random");
    check_cnts("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
